// File: rtl/uart_tx_arb_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_arb_pkg
// Shared definitions for the frame-safe UART TX arbiter.
//   uart_tx_arb_state_t : arbiter FSM states. The 2-bit encodings are fixed
//                         so they match the legacy localparam values.
//   arb_cnt_width()     : width of the idle and timeout counters, wide enough
//                         to hold TIMEOUT_BITS*BAUD_PERIOD without wrapping.
// -----------------------------------------------------------------------------
package uart_tx_arb_pkg;

    typedef enum logic [1:0] {
        ST_CPU   = 2'd0,
        ST_OCD   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_GUARD = 2'd3
    } uart_tx_arb_state_t;

    function automatic int unsigned arb_cnt_width(input int unsigned timeout_bits,
                                                  input int unsigned baud_period);
        int unsigned w;
        w = $clog2(timeout_bits * baud_period + 1);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/uart_idle_detector.sv
// -----------------------------------------------------------------------------
// uart_idle_detector
// Saturating counter of consecutive mark (1) cycles on a UART line.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   clear       : synchronous clear of the run counter (wins over counting)
//   line        : monitored UART line
//   threshold   : run length that counts as idle
//   idle        : high in the cycle whose sampled mark brings the run to
//                 threshold, so the owner can act on the same clock edge
// -----------------------------------------------------------------------------
module uart_idle_detector
    import uart_tx_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             line,
    input  logic [WIDTH-1:0] threshold,
    output logic             idle
);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] count_inc;

    // Run length including the current sample; any space restarts the run,
    // and the counter holds at all-ones rather than wrapping.
    always_comb begin
        count_inc = count;
        if (!line) begin
            count_inc = '0;
        end else if (count != '1) begin
            count_inc = count + 1'b1;
        end
    end

    // Look-ahead compare: idle is not gated by clear, which keeps the owner's
    // clear-on-transition free of a combinational loop.
    assign idle = line && (count_inc >= threshold);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else begin
            count <= count_inc;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Frame-safe switch of the board UART TX pin between the CPU UART and the
// on-chip debug coprocessor (OCD) UART. A select change waits until the old
// source has been idle for IDLE_BITS bit-times, then the pin is held at mark
// until the new source has been idle for one bit-time.
//
// Optional feature macro: UART_TX_ARB_TIMEOUT_EN
//   defined   : drain gives up after TIMEOUT_BITS bit-times and forces the
//               switch, pulsing timeout_pulse for one cycle.
//   undefined : drain waits indefinitely, timeout_pulse is tied low.
//
// Ports:
//   clk                  : system clock
//   reset                : asynchronous active-high reset
//   sel_ocd1_cpu0_req    : requested source (1 = OCD, 0 = CPU), level
//   uart_tx_cpu          : CPU UART TX line
//   uart_tx_ocd          : OCD UART TX line
//   UART_TXD             : registered pin drive
//   sel_ocd1_cpu0_active : source currently routed to the pin
//   switch_pending       : high while draining or guarding
//   timeout_pulse        : one-cycle pulse on a forced switch
// -----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int unsigned BAUD_PERIOD  = 868,
    parameter int unsigned IDLE_BITS    = 2,
    parameter int unsigned TIMEOUT_BITS = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic sel_ocd1_cpu0_req,
    input  logic uart_tx_cpu,
    input  logic uart_tx_ocd,
    output logic UART_TXD,
    output logic sel_ocd1_cpu0_active,
    output logic switch_pending,
    output logic timeout_pulse
);

    localparam int unsigned CNT_W = arb_cnt_width(TIMEOUT_BITS, BAUD_PERIOD);
    localparam logic [CNT_W-1:0] DRAIN_THRESH = CNT_W'(IDLE_BITS * BAUD_PERIOD);
    localparam logic [CNT_W-1:0] GUARD_THRESH = CNT_W'(BAUD_PERIOD);

    uart_tx_arb_state_t state;
    uart_tx_arb_state_t state_next;
    logic               cur_sel;
    logic               cur_sel_next;
    logic               src_line;
    logic               det_clear;
    logic               det_idle;
    logic [CNT_W-1:0]   det_threshold;
    logic               timeout_hit;
    logic               txd_next;

    // cur_sel flips on the drain->guard transition, so the same mux watches
    // the old source while draining and the new source while guarding.
    assign src_line      = cur_sel ? uart_tx_ocd : uart_tx_cpu;
    assign det_threshold = (state == ST_GUARD) ? GUARD_THRESH : DRAIN_THRESH;

    uart_idle_detector #(
        .WIDTH (CNT_W)
    ) u_idle (
        .clk       (clk),
        .reset     (reset),
        .clear     (det_clear),
        .line      (src_line),
        .threshold (det_threshold),
        .idle      (det_idle)
    );

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_THRESH = CNT_W'(TIMEOUT_BITS * BAUD_PERIOD);

    logic [CNT_W-1:0] tmo_count;
    logic [CNT_W-1:0] tmo_inc;
    logic             timeout_fire;

    always_comb begin
        tmo_inc = tmo_count;
        if (tmo_count != '1) begin
            tmo_inc = tmo_count + 1'b1;
        end
    end

    // Counts drain cycles only; held at zero elsewhere so every drain entry
    // starts from a cleared count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_count <= '0;
        end else if (state != ST_DRAIN) begin
            tmo_count <= '0;
        end else begin
            tmo_count <= tmo_inc;
        end
    end

    assign timeout_hit = (state == ST_DRAIN) && (tmo_inc >= TIMEOUT_THRESH);

    // A natural idle or a withdrawn request in the same cycle is not a
    // forced switch.
    assign timeout_fire = timeout_hit && !det_idle &&
                          (sel_ocd1_cpu0_req != cur_sel);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= timeout_fire;
        end
    end
`else
    assign timeout_hit   = 1'b0;
    assign timeout_pulse = 1'b0;
`endif

    always_comb begin
        state_next   = state;
        cur_sel_next = cur_sel;
        det_clear    = 1'b0;
        unique case (state)
            ST_CPU, ST_OCD: begin
                det_clear = 1'b1;
                if (sel_ocd1_cpu0_req != cur_sel) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (sel_ocd1_cpu0_req == cur_sel) begin
                    state_next = cur_sel ? ST_OCD : ST_CPU;
                    det_clear  = 1'b1;
                end else if (det_idle || timeout_hit) begin
                    state_next   = ST_GUARD;
                    cur_sel_next = ~cur_sel;
                    det_clear    = 1'b1;
                end
            end
            ST_GUARD: begin
                if (det_idle) begin
                    state_next = cur_sel ? ST_OCD : ST_CPU;
                    det_clear  = 1'b1;
                end
            end
            default: begin
                state_next   = ST_CPU;
                cur_sel_next = 1'b0;
                det_clear    = 1'b1;
            end
        endcase
    end

    // Mark is forced for the whole guard, including the edge that leaves it.
    assign txd_next = (state == ST_GUARD) ? 1'b1 : src_line;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_CPU;
            cur_sel        <= 1'b0;
            UART_TXD       <= 1'b1;
            switch_pending <= 1'b0;
        end else begin
            state          <= state_next;
            cur_sel        <= cur_sel_next;
            UART_TXD       <= txd_next;
            switch_pending <= (state_next == ST_DRAIN) || (state_next == ST_GUARD);
        end
    end

    assign sel_ocd1_cpu0_active = cur_sel;

endmodule
